// File: rtl/frame_deserializer.sv
// frame_deserializer
//   Serial-to-parallel frame receiver. Hunts the sampled bit stream for
//   SYNC_PAT, then shifts in a DATA_W-bit payload MSB-first. The completed
//   word is presented on a valid/ready output backed by a one-entry holding
//   register.
//
//   Optional feature macro: FRAME_PARITY_EN
//     defined   -> each frame carries one trailing even-parity bit; frames
//                  with bad parity are dropped and par_err pulses.
//     undefined -> no parity bit; par_err is constant 0.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   bit_en     sample strobe; data_in is sampled only when high
//   data_in    serial data
//   out_data   completed payload, first-received bit in the MSB
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer takes the word on an edge where valid && ready
//   ovf        one-cycle pulse: completed frame dropped, holding reg full
//   par_err    one-cycle pulse: parity mismatch, frame dropped
//   busy       high whenever the receiver is not hunting for sync
//
// State table
//   state   | meaning
//   ST_HUNT | searching the bit stream for the sync pattern
//   ST_DATA | shifting in payload bits
//   ST_PAR  | waiting for the trailing parity bit (FRAME_PARITY_EN only)

module frame_deserializer #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       SYNC_W   = 2,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 2'b11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              data_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf,
  output logic              par_err,
  output logic              busy
);

  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam int unsigned FILL_W = $clog2(SYNC_W + 1);

`ifdef FRAME_PARITY_EN
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_e;
  // Parity needs the whole payload held until the parity bit arrives.
  localparam int unsigned SHIFT_W = DATA_W;
`else
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_DATA = 1'b1
  } state_e;
  // Without parity the last payload bit is taken straight from data_in,
  // so only DATA_W-1 bits ever need to be stored.
  localparam int unsigned SHIFT_W = DATA_W - 1;
`endif

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   win_q, win_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                ovf_q, ovf_d;
  logic                frame_done;
  logic [DATA_W-1:0]   frame_word;
`ifdef FRAME_PARITY_EN
  logic                par_bad;
  logic                par_err_q;
`endif

  // Receive FSM: next state, window, counters and shift register.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    frame_word = '0;
`ifdef FRAME_PARITY_EN
    par_bad    = 1'b0;
`endif
    if (bit_en) begin
      case (state_q)
        ST_HUNT: begin
          win_d  = SYNC_W'({win_q, data_in});
          fill_d = (fill_q == FILL_W'(SYNC_W)) ? fill_q : fill_q + FILL_W'(1);
          // Match uses the window including the bit sampled on this edge.
          if (fill_d == FILL_W'(SYNC_W) && win_d == SYNC_PAT) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d = SHIFT_W'({shift_q, data_in});
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef FRAME_PARITY_EN
            state_d    = ST_PAR;
`else
            state_d    = ST_HUNT;
            frame_done = 1'b1;
            frame_word = {shift_q, data_in};
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef FRAME_PARITY_EN
        ST_PAR: begin
          state_d = ST_HUNT;
          if (data_in ^ (^shift_q)) begin
            par_bad = 1'b1;
          end else begin
            frame_done = 1'b1;
            frame_word = shift_q;
          end
        end
`endif
        default: state_d = ST_HUNT;
      endcase
    end
    // Fresh sync search on every return to HUNT: payload bits never count as sync.
    if (state_d == ST_HUNT && state_q != ST_HUNT) begin
      win_d  = '0;
      fill_d = '0;
    end
  end

  // One-entry holding register with valid/ready handshake.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = 1'b0;
    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = frame_word;
        out_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      win_q       <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef FRAME_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_bad;
    end
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != ST_HUNT);

endmodule

// File: tb/tb_frame_deserializer.sv
// Testbench for frame_deserializer (default parameters: 32-bit payload,
// sync pattern 2'b11). Frames are generated at the transaction level; the
// expected words, overflow pulses and parity-error pulses are queued by the
// driver and consumed by an independent monitor.

module tb_frame_deserializer;

  localparam int DATA_W = 32;
`ifdef FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              bit_en    = 1'b0;
  logic              data_in   = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              ovf;
  logic              par_err;
  logic              busy;

  frame_deserializer #(
    .DATA_W  (DATA_W),
    .SYNC_W  (2),
    .SYNC_PAT(2'b11)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_en   (bit_en),
    .data_in  (data_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf      (ovf),
    .par_err  (par_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] exp_q[$];
  int                ovf_exp[$];
  int                perr_exp[$];
  bit                mv       = 1'b0;  // model: holding register occupied
  int                rdy_mode = 1;     // 0: never ready, 1: always, 2: random, 3: only on completion
  int                en_mode  = 0;     // 0: every cycle, 1: 1-in-3, 2: random gaps

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: got %h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // One clock: drive inputs on the falling edge and update the
  // transaction-level model of the output holding register for the next rising edge.
  task automatic drive_cycle(input bit en, input bit d, input bit done,
                             input logic [DATA_W-1:0] w, input bit perr);
    bit rdy;
    @(negedge clk);
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = done;
    endcase
    bit_en    = en;
    data_in   = d;
    out_ready = rdy;
    if (done) begin
      if (!mv || rdy) begin
        exp_q.push_back(w);
        mv = 1'b1;
      end else begin
        ovf_exp.push_back(cyc + 1);
      end
    end else if (mv && rdy) begin
      mv = 1'b0;
    end
    if (perr) perr_exp.push_back(cyc + 1);
  endtask

  // Sends noise bits (noise[nlen-1] first), sync 1,1, payload MSB-first and,
  // when built with parity, the parity bit. abort_after >= 0 stops after that
  // many payload bits.
  task automatic send_frame(input logic [DATA_W-1:0] w, input logic [15:0] noise,
                            input int nlen, input bit par_good, input int abort_after);
    bit q[$];
    int last;
    for (int k = nlen - 1; k >= 0; k--) q.push_back(noise[k]);
    q.push_back(1'b1);
    q.push_back(1'b1);
    for (int k = DATA_W - 1; k >= 0; k--) q.push_back(w[k]);
    if (PAR_EN) q.push_back(par_good ? ^w : ~^w);
    if (abort_after >= 0)
      while (q.size() > nlen + 2 + abort_after) void'(q.pop_back());
    last = q.size() - 1;
    foreach (q[i]) begin
      bit fin;
      int gap;
      fin = (i == last) && (abort_after < 0);
      gap = (en_mode == 1) ? 2 : (en_mode == 2) ? $urandom_range(0, 2) : 0;
      repeat (gap) drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
      drive_cycle(1'b1, q[i], fin && par_good, w, fin && !par_good);
    end
  endtask

  // Noise that can never form the sync pattern: no two adjacent ones and a
  // trailing zero so the sync bits that follow are not absorbed early.
  task automatic rand_noise(output logic [15:0] n, output int len);
    bit prev;
    bit b;
    prev = 1'b0;
    n    = '0;
    len  = $urandom_range(0, 8);
    for (int k = len - 1; k >= 0; k--) begin
      b    = (prev || k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      n[k] = b;
      prev = b;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Monitor: decoupled from stimulus, consumes the expectation queues.
  bit                prev_valid = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  always @(posedge clk) begin
    logic [DATA_W-1:0] w;
    int                c;
    #1;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("word_unexpected", prev_data);
        else begin
          w = exp_q.pop_front();
          chk("word", prev_data, w);
        end
      end else if (prev_valid) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_data);
      end
      if (ovf) begin
        if (ovf_exp.size() == 0) fail_now("ovf_unexpected", ovf);
        else begin
          c = ovf_exp.pop_front();
          chk("ovf_cycle", cyc, c);
        end
      end
      if (par_err) begin
        if (perr_exp.size() == 0) fail_now("par_err_unexpected", par_err);
        else begin
          c = perr_exp.pop_front();
          chk("par_err_cycle", cyc, c);
        end
      end
      prev_valid = out_valid;
      prev_data  = out_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] nz;
    int          nl;
    logic [DATA_W-1:0] w;
    bit          pg;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_par_err", par_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Basic frame, ready always high
    en_mode = 0; rdy_mode = 1;
    send_frame(32'hA5A5_1234, 16'h0, 0, 1'b1, -1);
    @(posedge clk); #2;
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 32'hA5A5_1234);
    idle(1);
    @(posedge clk); #2;
    chk("t1_valid_drop", out_valid, 1'b0);

    // Noise 0,1,0 ahead of the sync bits
    send_frame(32'hFFFF_0000, 16'b010, 3, 1'b1, -1);
    idle(3);
    @(posedge clk); #2;
    chk("t2_queue_empty", exp_q.size(), 0);

    // Backpressure: second frame overflows
    rdy_mode = 0;
    send_frame(32'h0000_0001, 16'h0, 0, 1'b1, -1);
    send_frame(32'h0000_0002, 16'h0, 0, 1'b1, -1);
    @(posedge clk); #2;
    chk("t3_data_kept", out_data, 32'h1);
    chk("t3_ovf", ovf, 1'b1);
    rdy_mode = 1;
    idle(1);
    @(posedge clk); #2;
    chk("t3_valid_clear", out_valid, 1'b0);
    chk("t3_ovf_once", ovf, 1'b0);

    // Completion with ready while full: replace, no overflow
    rdy_mode = 0;
    send_frame(32'h0000_0003, 16'h0, 0, 1'b1, -1);
    rdy_mode = 3;
    send_frame(32'h0000_0004, 16'h0, 0, 1'b1, -1);
    @(posedge clk); #2;
    chk("t4_data", out_data, 32'h4);
    chk("t4_valid", out_valid, 1'b1);
    chk("t4_no_ovf", ovf, 1'b0);
    rdy_mode = 1;
    idle(2);

`ifdef FRAME_PARITY_EN
    send_frame(32'h0000_0001, 16'h0, 0, 1'b1, -1);
    @(posedge clk); #2;
    chk("t5_good_valid", out_valid, 1'b1);
    chk("t5_good_data", out_data, 32'h1);
    idle(2);
    send_frame(32'h0000_0001, 16'h0, 0, 1'b0, -1);
    @(posedge clk); #2;
    chk("t5_bad_par_err", par_err, 1'b1);
    chk("t5_bad_valid", out_valid, 1'b0);
    idle(2);
`endif

    // Sparse bit_en, reset after 10 payload bits, then a clean frame
    en_mode = 1;
    send_frame(32'hDEAD_BEEF, 16'h0, 0, 1'b1, 10);
    @(posedge clk); #2;
    chk("t6_busy_mid", busy, 1'b1);
    @(negedge clk);
    rst_n  = 1'b0;
    bit_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mv    = 1'b0;
    #1;
    chk("t6_busy_rst", busy, 1'b0);
    chk("t6_valid_rst", out_valid, 1'b0);
    chk("t6_queue_empty", exp_q.size(), 0);
    send_frame(32'h5A5A_C3C3, 16'h0, 0, 1'b1, -1);
    @(posedge clk); #2;
    chk("t6_data", out_data, 32'h5A5A_C3C3);
    chk("t6_valid", out_valid, 1'b1);
    idle(2);

    // Randomized frames
    for (int f = 0; f < 120; f++) begin
      w        = {$urandom};
      pg       = PAR_EN ? ($urandom_range(0, 3) != 0) : 1'b1;
      en_mode  = $urandom_range(0, 2);
      rdy_mode = $urandom_range(0, 2);
      rand_noise(nz, nl);
      send_frame(w, nz, nl, pg, -1);
    end

    // Drain and confirm nothing is left outstanding
    rdy_mode = 1;
    idle(4);
    @(posedge clk); #2;
    chk("end_words_left", exp_q.size(), 0);
    chk("end_ovf_left", ovf_exp.size(), 0);
    chk("end_par_err_left", perr_exp.size(), 0);
    chk("end_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_deserializer.md
# frame_deserializer

Parametrised serial-to-parallel frame receiver for the self-test data path. It hunts a serial bit stream for a configurable sync pattern, then shifts in a DATA_W-bit payload MSB-first, optionally checks a trailing even-parity bit, and presents each completed word on a valid/ready output with a one-entry holding register. It is the generalised, handshake-capable successor to the fixed 32-bit preamble-triggered deserializer.

## Interface
- DATA_W, 32: payload width in bits, 2..64.
- SYNC_W, 2: sync pattern length in bits, 1..8.
- SYNC_PAT, 2'b11: sync pattern, SYNC_W bits wide; the first-received bit is the MSB.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- bit_en  input  1  sample strobe; data_in is sampled only on clk edges where bit_en=1.
- data_in  input  1  serial data.
- out_data  output  DATA_W  completed payload; the first-received bit is the MSB.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word on the edge where out_valid&&out_ready.
- ovf  output  1  one-cycle pulse: a completed frame was dropped because the holding register was full.
- par_err  output  1  one-cycle pulse: parity mismatch, frame dropped. Tied 0 when parity is compiled out.
- busy  output  1  high in any state other than HUNT.

## Operation
- States: HUNT, DATA, PAR (PAR exists only with FRAME_PARITY_EN).
- HUNT: each sampled bit shifts into a SYNC_W-bit window; a fill counter saturates at SYNC_W. When the fill counter equals SYNC_W and the window (including the bit sampled this edge) equals SYNC_PAT, the next state is DATA and the bit counter clears to 0. Window and fill counter clear on every entry to HUNT, so payload bits are never reused as sync.
- DATA: each sampled bit shifts into the payload shift register; the bit counter increments. On the sample with counter = DATA_W-1, the next state is PAR if parity is enabled, otherwise the frame completes and the next state is HUNT.
- PAR: the sampled bit is XORed with the reduction-XOR of the payload. A result of 0 completes the frame. A result of 1 pulses par_err, drops the frame, and returns to HUNT.
- Frame completion, evaluated on the same edge:
  - out_valid=0: load out_data, set out_valid.
  - out_valid=1 and out_ready=1: the old word is consumed and the new word loads; out_valid stays 1.
  - out_valid=1 and out_ready=0: the new frame is dropped, out_data is kept, ovf pulses.
- No completion, out_valid&&out_ready: clear out_valid.
- bit_en=0: state, counters and shift registers hold. The output handshake still operates.
- Counter width is $clog2(DATA_W); it never wraps past DATA_W-1.

## Timing
- Reset values: out_data=0, out_valid=0, ovf=0, par_err=0, busy=0, state=HUNT, all counters and windows 0.
- Reset asserted mid-frame aborts the frame immediately. No partial word is ever presented.
- Latency: out_valid rises on the clk edge that samples the last payload bit (or the parity bit). It is visible the following cycle.
- Minimum frame length is SYNC_W + DATA_W samples (+1 with parity). Back-to-back frames need no idle bits.
- ovf and par_err are registered and high for exactly one cycle per event.
- out_data is stable while out_valid=1 and out_ready=0.

## Configuration
- FRAME_PARITY_EN defined: PAR state present; each frame carries one trailing even-parity bit; par_err is active.
- FRAME_PARITY_EN undefined: PAR state removed; the frame completes after the last payload bit; par_err is constant 0.

## Test plan
- Defaults, no parity, bit_en=1, out_ready=1: send 1,1 then 0xA5A5_1234 MSB-first -> out_valid=1 for one cycle with out_data=0xA5A5_1234, one cycle after the 34th bit.
- Noise before sync: send 0,1,0,1,1 then 0xFFFF_0000 -> exactly one word, 0xFFFF_0000; no spurious early frame.
- Backpressure, out_ready=0: send two frames, 0x1 then 0x2 -> out_data stays 0x1, ovf pulses once at the second completion; raising out_ready then clears out_valid.
- Completion coinciding with out_ready=1 while full -> the new word replaces the old, out_valid stays 1, no ovf.
- FRAME_PARITY_EN: send 0x0000_0001 with parity bit 1 -> word accepted; with parity bit 0 -> par_err pulses, out_valid stays 0.
- bit_en toggling 1-in-3, plus rst_n pulsed after 10 payload bits -> busy=0, no output; the next full frame is received correctly.
